// File: rtl/video_timing_gen.sv
// Raster timing generator: waits for a synchronized, settled PLL lock, then
// sweeps h/v counters and emits registered hsync/vsync/de/x/y/frame_start.
module video_timing_gen #(
  parameter int   H_ACTIVE      = 1280,
  parameter int   H_FP          = 110,
  parameter int   H_SYNC        = 40,
  parameter int   H_BP          = 220,
  parameter int   V_ACTIVE      = 720,
  parameter int   V_FP          = 5,
  parameter int   V_SYNC        = 5,
  parameter int   V_BP          = 20,
  parameter logic HS_POL        = 1'b1,
  parameter logic VS_POL        = 1'b1,
  parameter int   SETTLE_CYCLES = 16
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        lock,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  // Decode boundaries are one bit wider than the counters so that an edge
  // landing exactly on 2048/1024 still compares correctly.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT_E  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG_E = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_E = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG_E = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END_E = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("video_timing_gen: H_TOTAL does not fit the 11-bit h counter");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("video_timing_gen: V_TOTAL does not fit the 10-bit v counter");
  end
  if (SETTLE_CYCLES < 1) begin : g_settle_chk
    $error("video_timing_gen: SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        state;
  logic          lock_m;
  logic          lock_s;
  logic [SW-1:0] settle_cnt;
  logic [10:0]   h_cnt;
  logic [9:0]    v_cnt;

  logic        de_d;
  logic        hsync_d;
  logic        vsync_d;
  logic        fs_d;
  logic [11:0] h_ext;
  logic [10:0] v_ext;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    h_ext   = {1'b0, h_cnt};
    v_ext   = {1'b0, v_cnt};
    de_d    = (h_ext < H_ACT_E) && (v_ext < V_ACT_E);
    hsync_d = ((h_ext >= HS_BEG_E) && (h_ext < HS_END_E)) ? HS_POL : ~HS_POL;
    vsync_d = ((v_ext >= VS_BEG_E) && (v_ext < VS_END_E)) ? VS_POL : ~VS_POL;
    fs_d    = (h_cnt == 11'd0) && (v_cnt == 10'd0);
  end

  // Outputs only leave their idle values inside RUN, and every exit from RUN
  // forces them back, so WAIT_LOCK/SETTLE never need to touch them.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      settle_cnt  <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      running     <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          settle_cnt <= '0;
          h_cnt      <= '0;
          v_cnt      <= '0;
          if (lock_s) state <= SETTLE;
        end
        SETTLE: begin
          if (!lock_s) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= RUN;
            running    <= 1'b1;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state       <= WAIT_LOCK;
            running     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
          end else begin
            de          <= de_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            frame_start <= fs_d;
            if (de_d) begin
              x <= h_cnt;
              y <= v_cnt;
            end
            if (h_cnt == H_LAST) begin
              h_cnt <= '0;
              v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 1'b1;
            end else begin
              h_cnt <= h_cnt + 1'b1;
            end
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule
